// File: rtl/fpu_issue_stage.sv
// fpu_issue_stage: operand fetch and issue stage feeding the FPU execute stage.
// Reads two operands from a 16x32 register file and issues one instruction per
// cycle. A per-register busy scoreboard stalls RAW and WAW hazards until the
// pending result returns on the writeback port.
// Optional feature macro: FPU_ISSUE_BYPASS_EN forwards wb_data to the operands
// and lets a same-cycle writeback release a hazard.
module fpu_issue_stage #(
  parameter int unsigned NREGS       = 16,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_flags,
  output logic [3:0]  out_rd
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned FW = 4;

  // Instruction field decode
  logic [1:0]    op;
  logic [1:0]    rsvd;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;

  assign op   = in_instr[15:14];
  assign rsvd = in_instr[13:12];
  assign rd   = in_instr[11:8];
  assign rs1  = in_instr[7:4];
  assign rs2  = in_instr[3:0];

  // State
  logic [DW-1:0]    rf_q [NREGS];
  logic [DW-1:0]    rf_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             illegal_seen_q;
  logic             illegal_seen_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [DW-1:0]    out_a_q;
  logic [DW-1:0]    out_a_d;
  logic [DW-1:0]    out_b_q;
  logic [DW-1:0]    out_b_d;
  logic [FW-1:0]    out_flags_q;
  logic [FW-1:0]    out_flags_d;
  logic [AW-1:0]    out_rd_q;
  logic [AW-1:0]    out_rd_d;

  // Hazard evaluation and operand selection
  logic [NREGS-1:0] wb_mask;
  logic [NREGS-1:0] busy_eff;
  logic [DW-1:0]    opnd_a;
  logic [DW-1:0]    opnd_b;
  logic             stall;
  logic             accept;

  // Busy view used for the stall check, and operand read with optional forwarding
  always_comb begin
    wb_mask = wb_en ? (NREGS'(1) << wb_addr) : '0;
`ifdef FPU_ISSUE_BYPASS_EN
    busy_eff = busy_q & ~wb_mask;
    opnd_a   = (wb_en && (wb_addr == rs1)) ? wb_data : rf_q[rs1];
    opnd_b   = (wb_en && (wb_addr == rs2)) ? wb_data : rf_q[rs2];
`else
    busy_eff = busy_q;
    opnd_a   = rf_q[rs1];
    opnd_b   = rf_q[rs2];
`endif
    stall  = busy_eff[rs1] | busy_eff[rs2] | busy_eff[rd];
    accept = in_valid & ~stall;
  end

  assign in_ready = ~stall;

  // Register file write from the writeback port
  always_comb begin
    rf_d = rf_q;
    if (wb_en) begin
      rf_d[wb_addr] = wb_data;
    end
  end

  // Scoreboard: writeback clears first so a same-cycle issue to that register wins
  always_comb begin
    busy_d = busy_q & ~wb_mask;
    if (accept) begin
      busy_d[rd] = 1'b1;
    end
    illegal_seen_d = illegal_seen_q | (accept & (rsvd != 2'b00));
  end

  // Issue outputs: operands and tag hold on bubbles, flags return to idle value
  always_comb begin
    out_valid_d = 1'b0;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_flags_d = RESET_FLAGS;
    out_rd_d    = out_rd_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_a_d     = opnd_a;
      out_b_d     = opnd_b;
      out_flags_d = FW'(1) << op;
      out_rd_d    = rd;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        rf_q[i] <= '0;
      end
      busy_q         <= '0;
      illegal_seen_q <= 1'b0;
      out_valid_q    <= 1'b0;
      out_a_q        <= '0;
      out_b_q        <= '0;
      out_flags_q    <= RESET_FLAGS;
      out_rd_q       <= '0;
    end else begin
      rf_q           <= rf_d;
      busy_q         <= busy_d;
      illegal_seen_q <= illegal_seen_d;
      out_valid_q    <= out_valid_d;
      out_a_q        <= out_a_d;
      out_b_q        <= out_b_d;
      out_flags_q    <= out_flags_d;
      out_rd_q       <= out_rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_flags = out_flags_q;
  assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_fpu_issue_stage.sv
// Testbench for fpu_issue_stage: directed scenarios plus a randomized run
// checked against a register-file/scoreboard reference model.
module tb_fpu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_flags;
  logic [3:0]  out_rd;

  int checks = 0;
  int errors = 0;

  fpu_issue_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_flags (out_flags),
    .out_rd    (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_rf [16];
  logic [15:0] m_busy;
  logic        m_valid;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [3:0]  m_flags;
  logic [3:0]  m_rd;

`ifdef FPU_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int rs2);
    return {2'(op), 2'b00, 4'(rd), 4'(rs1), 4'(rs2)};
  endfunction

  function automatic logic [3:0] flag_of(input logic [1:0] op);
    case (op)
      2'd0: return 4'b0001;
      2'd1: return 4'b0010;
      2'd2: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // A register blocks issue if it is pending, unless bypass releases it this cycle
  function automatic bit reg_blocked(input logic [3:0] r);
    if (BYP && wb_en && (wb_addr == r)) return 1'b0;
    return m_busy[r];
  endfunction

  function automatic bit model_ready();
    return !(reg_blocked(in_instr[11:8]) || reg_blocked(in_instr[7:4]) ||
             reg_blocked(in_instr[3:0]));
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] r);
    if (BYP && wb_en && (wb_addr == r)) return wb_data;
    return m_rf[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_busy = '0; m_valid = 1'b0; m_a = '0; m_b = '0; m_flags = 4'b0000; m_rd = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    bit          acc;
    logic [31:0] a;
    logic [31:0] b;
    acc = in_valid && model_ready();
    a = model_read(in_instr[7:4]);
    b = model_read(in_instr[3:0]);
    if (wb_en) begin
      m_rf[wb_addr]   = wb_data;
      m_busy[wb_addr] = 1'b0;
    end
    if (acc) begin
      m_busy[in_instr[11:8]] = 1'b1;
      m_valid = 1'b1; m_a = a; m_b = b;
      m_flags = flag_of(in_instr[15:14]); m_rd = in_instr[11:8];
    end else begin
      m_valid = 1'b0; m_flags = 4'b0000;
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic we,
                       input logic [3:0] wa, input logic [31:0] wd);
    in_valid = v; in_instr = ins; wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input int addr, input logic [31:0] data);
    drive(1'b0, 16'h0, 1'b1, 4'(addr), data);
    tick();
    drive(1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    drive(1'b1, mk(2, 3, 4, 5), 1'b0, 4'h0, 32'h0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    checks++;
    if ({out_valid, out_a, out_b, out_flags, out_rd} !== {1'b0, 32'h0, 32'h0, 4'b0000, 4'h0}) begin
      errors++;
      $display("FAIL reset_outs got v=%b a=%h b=%h f=%b rd=%h want all zero", out_valid, out_a, out_b, out_flags, out_rd);
    end
    checks++;
    if ({dut.busy_q, dut.illegal_seen_q} !== 17'h0) begin
      errors++; $display("FAIL reset_state got busy=%h ill=%b want 0", dut.busy_q, dut.illegal_seen_q);
    end
    drive(1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_preload_add();
    wb(1, 32'h3F800000);
    wb(2, 32'h40000000);
    drive(1'b1, mk(0, 3, 1, 2), 1'b0, 4'h0, 32'h0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b want 1", in_ready); end
    tick();
    drive(1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
    checks++;
    if ({out_valid, out_a, out_b, out_flags, out_rd} !== {1'b1, 32'h3F800000, 32'h40000000, 4'b0001, 4'd3}) begin
      errors++;
      $display("FAIL add_issue got v=%b a=%h b=%h f=%b rd=%0d want 1 3f800000 40000000 0001 3", out_valid, out_a, out_b, out_flags, out_rd);
    end
    checks++; if (dut.busy_q[3] !== 1'b1) begin errors++; $display("FAIL add_busy3 got %b want 1", dut.busy_q[3]); end
    tick();
    checks++;
    if ({out_valid, out_flags, out_a} !== {1'b0, 4'b0000, 32'h3F800000}) begin
      errors++; $display("FAIL bubble_hold got v=%b f=%b a=%h want 0 0000 3f800000", out_valid, out_flags, out_a);
    end
    wb(3, 32'h40400000);
  endtask

  task automatic test_back_to_back();
    logic [3:0] want [3];
    want[0] = 4'b0010; want[1] = 4'b0100; want[2] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(i + 1, 8 + i, 1, 2), 1'b0, 4'h0, 32'h0);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
      tick();
      checks++;
      if ({out_valid, out_flags, out_rd} !== {1'b1, want[i], 4'(8 + i)}) begin
        errors++; $display("FAIL b2b_out[%0d] got v=%b f=%b rd=%0d want 1 %b %0d", i, out_valid, out_flags, out_rd, want[i], 8 + i);
      end
    end
    drive(1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
    for (int i = 8; i < 11; i++) wb(i, 32'h0);
  endtask

  task automatic test_raw();
    drive(1'b1, mk(2, 4, 1, 2), 1'b0, 4'h0, 32'h0);
    tick();
    drive(1'b1, mk(0, 11, 4, 2), 1'b0, 4'h0, 32'h0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got %b want 0", in_ready); end
    tick();
    checks++;
    if ({out_valid, out_flags} !== 5'b0_0000) begin
      errors++; $display("FAIL raw_bubble got v=%b f=%b want 0 0000", out_valid, out_flags);
    end
    drive(1'b1, mk(0, 11, 4, 2), 1'b1, 4'd4, 32'h40400000);
    #1;
    checks++; if (in_ready !== BYP) begin errors++; $display("FAIL raw_wb_ready got %b want %b", in_ready, BYP); end
    tick();
    if (!BYP) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_nobyp_wait got %b want 0", out_valid); end
      drive(1'b1, mk(0, 11, 4, 2), 1'b0, 4'h0, 32'h0);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release got %b want 1", in_ready); end
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
    checks++;
    if ({out_valid, out_a, out_b, out_rd} !== {1'b1, 32'h40400000, 32'h40000000, 4'd11}) begin
      errors++; $display("FAIL raw_issue got v=%b a=%h b=%h rd=%0d want 1 40400000 40000000 11", out_valid, out_a, out_b, out_rd);
    end
    wb(11, 32'h0);
  endtask

  task automatic test_waw();
    drive(1'b1, mk(0, 5, 1, 2), 1'b0, 4'h0, 32'h0);
    tick();
    drive(1'b1, mk(1, 5, 2, 1), 1'b0, 4'h0, 32'h0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_stall got %b want 0", in_ready); end
    tick();
    drive(1'b1, mk(1, 5, 2, 1), 1'b1, 4'd5, 32'h12345678);
    tick();
    if (!BYP) begin
      checks++; if (dut.busy_q[5] !== 1'b0) begin errors++; $display("FAIL waw_cleared got %b want 0", dut.busy_q[5]); end
      drive(1'b1, mk(1, 5, 2, 1), 1'b0, 4'h0, 32'h0);
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
    checks++;
    if ({out_valid, out_flags, out_rd, dut.busy_q[5]} !== {1'b1, 4'b0010, 4'd5, 1'b1}) begin
      errors++; $display("FAIL waw_issue got v=%b f=%b rd=%0d busy5=%b want 1 0010 5 1", out_valid, out_flags, out_rd, dut.busy_q[5]);
    end
    wb(5, 32'h0);
  endtask

  task automatic test_reset_stall();
    drive(1'b1, mk(0, 6, 1, 2), 1'b0, 4'h0, 32'h0);
    tick();
    drive(1'b1, mk(2, 6, 1, 2), 1'b0, 4'h0, 32'h0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", in_ready); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({out_valid, out_a, out_b, out_flags, out_rd, dut.busy_q, in_ready} !== {1'b0, 64'h0, 4'b0000, 4'h0, 16'h0, 1'b1}) begin
      errors++;
      $display("FAIL rst_async got v=%b a=%h b=%h f=%b rd=%h busy=%h rdy=%b want zeros rdy=1", out_valid, out_a, out_b, out_flags, out_rd, dut.busy_q, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
    checks++;
    if ({out_valid, out_flags, out_rd, out_a} !== {1'b1, 4'b0100, 4'd6, 32'h0}) begin
      errors++; $display("FAIL rst_reissue got v=%b f=%b rd=%0d a=%h want 1 0100 6 0", out_valid, out_flags, out_rd, out_a);
    end
    wb(6, 32'h0);
  endtask

  task automatic test_same_src();
    wb(7, 32'hC0000000);
    drive(1'b1, mk(3, 12, 7, 7), 1'b0, 4'h0, 32'h0);
    tick();
    drive(1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
    checks++;
    if ({out_valid, out_a, out_b, out_flags} !== {1'b1, 32'hC0000000, 32'hC0000000, 4'b1000}) begin
      errors++; $display("FAIL same_src got v=%b a=%h b=%h f=%b want 1 c0000000 c0000000 1000", out_valid, out_a, out_b, out_flags);
    end
    wb(12, 32'h0);
  endtask

  task automatic test_reserved();
    logic [15:0] ins;
    ins = mk(1, 13, 1, 2);
    ins[13:12] = 2'b11;
    drive(1'b1, ins, 1'b0, 4'h0, 32'h0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rsvd_ready got %b want 1", in_ready); end
    tick();
    drive(1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
    checks++;
    if ({out_valid, out_flags, out_rd, dut.illegal_seen_q} !== {1'b1, 4'b0010, 4'd13, 1'b1}) begin
      errors++; $display("FAIL rsvd_issue got v=%b f=%b rd=%0d ill=%b want 1 0010 13 1", out_valid, out_flags, out_rd, dut.illegal_seen_q);
    end
    wb(13, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)),
            mk($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
            1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), $urandom);
      #1;
      checks++;
      if (in_ready !== model_ready()) begin
        errors++; $display("FAIL rnd_ready[%0d] got %b want %b", n, in_ready, model_ready());
      end
      tick();
      checks++;
      if ({out_valid, out_a, out_b, out_flags, out_rd, dut.busy_q} !== {m_valid, m_a, m_b, m_flags, m_rd, m_busy}) begin
        errors++;
        $display("FAIL rnd_out[%0d] got v=%b a=%h b=%h f=%b rd=%h busy=%h want v=%b a=%h b=%h f=%b rd=%h busy=%h",
                 n, out_valid, out_a, out_b, out_flags, out_rd, dut.busy_q, m_valid, m_a, m_b, m_flags, m_rd, m_busy);
      end
    end
    drive(1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
    model_reset();
    test_reset();
    test_preload_add();
    test_back_to_back();
    test_raw();
    test_waw();
    test_reset_stall();
    test_same_src();
    test_reserved();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
